// File: rtl/clock_step_gen.sv
// clock_step_gen: produces a one-cycle clk_en step pulse in one of three modes:
// free-run with a programmable divider, debounced manual single-step, or a
// burst of N divided steps. A halt level suppresses all steps. A wrapping
// count of issued steps is also kept.
module clock_step_gen #(
  parameter int DIV_W    = 8,
  parameter int CNT_W    = 16,
  parameter int DEBOUNCE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             manual_clk,
  input  logic             clk_select,
  input  logic [DIV_W-1:0] div_value,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             burst_start,
  input  logic             halt,
  output logic             clk_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic             busy
);

  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {S_MANUAL, S_RUN, S_BURST, S_HALT} state_t;

  // Synchroniser and debounce state
  logic            man_s1_q, man_s2_q, sel_s1_q, sel_s2_q;
  logic            acc_q, acc_prev_q;
  logic [DB_W-1:0] db_cnt_q;

  // Mode, divider and output state
  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, div_lat_q, div_lat_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q, clk_en_d;
  logic             busy_q, busy_d;

  logic step_req, tick, active;

  // A step request is the first cycle the debounced level is seen high.
  assign step_req = acc_q & ~acc_prev_q;
  assign tick     = (div_q == div_lat_q);

  // Two-flop synchronisers, then the debouncer: the accepted level follows the
  // synced button only after it has differed for DEBOUNCE consecutive cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      man_s1_q   <= 1'b0;
      man_s2_q   <= 1'b0;
      sel_s1_q   <= 1'b0;
      sel_s2_q   <= 1'b0;
      acc_q      <= 1'b0;
      acc_prev_q <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      man_s1_q   <= manual_clk;
      man_s2_q   <= man_s1_q;
      sel_s1_q   <= clk_select;
      sel_s2_q   <= sel_s1_q;
      acc_prev_q <= acc_q;
      if (man_s2_q != acc_q) begin
        if (db_cnt_q == DB_MAX) begin
          acc_q    <= man_s2_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DB_W'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  // Mode selection, pulse generation and divider control. Halt outranks a
  // mode change, which outranks burst_start / step requests.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    clk_en_d = 1'b0;
    active   = 1'b0;
    if (halt) begin
      state_d = S_HALT;
    end else begin
      case (state_q)
        S_MANUAL: begin
          if (!sel_s2_q) begin
            state_d = S_RUN;
          end else if (burst_start && (burst_len != '0)) begin
            state_d = S_BURST;
            rem_d   = burst_len;
          end else if (step_req) begin
            clk_en_d = 1'b1;
          end
        end
        S_RUN: begin
          if (sel_s2_q) begin
            state_d = S_MANUAL;
          end else begin
            active   = 1'b1;
            clk_en_d = tick;
          end
        end
        S_BURST: begin
          // Stay in BURST for the cycle after the last pulse so busy covers it.
          if (!sel_s2_q) begin
            state_d = S_RUN;
          end else if (rem_q == '0) begin
            state_d = S_MANUAL;
          end else begin
            active = 1'b1;
            if (tick) begin
              clk_en_d = 1'b1;
              rem_d    = rem_q - CNT_W'(1);
            end
          end
        end
        S_HALT:  state_d = sel_s2_q ? S_MANUAL : S_RUN;
        default: state_d = S_MANUAL;
      endcase
    end
    // Divider runs only while actively stepping; the period is resampled at
    // each wrap and tracks div_value while idle.
    div_d     = (active && !tick) ? div_q + DIV_W'(1) : '0;
    div_lat_d = (!active || tick) ? div_value : div_lat_q;
    busy_d    = (state_d == S_RUN) || (state_d == S_BURST);
    cnt_d     = cnt_q + CNT_W'(clk_en_d);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_MANUAL;
      div_q     <= '0;
      div_lat_q <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      clk_en_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      div_lat_q <= div_lat_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      clk_en_q  <= clk_en_d;
      busy_q    <= busy_d;
    end
  end

  assign clk_en      = clk_en_q;
  assign cycle_count = cnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_clock_step_gen.sv
// Bench for clock_step_gen: randomized scenarios checked against expected
// pulse timing derived from the mode rules (period d+1, DEBOUNCE+3 latency).
module tb_clock_step_gen;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset, manual_clk, clk_select, burst_start, halt;
  logic [7:0]  div_value;
  logic [15:0] burst_len;
  logic        clk_en, busy, clk_en_w, busy_w;
  logic [15:0] cycle_count;
  logic [3:0]  cycle_count_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clock_step_gen #(.DIV_W(8), .CNT_W(16), .DEBOUNCE(DEB)) u_dut (
    .clk(clk), .reset(reset), .manual_clk(manual_clk), .clk_select(clk_select),
    .div_value(div_value), .burst_len(burst_len), .burst_start(burst_start),
    .halt(halt), .clk_en(clk_en), .cycle_count(cycle_count), .busy(busy));

  // Narrow-counter instance for the wrap-around check.
  clock_step_gen #(.DIV_W(8), .CNT_W(4), .DEBOUNCE(DEB)) u_w (
    .clk(clk), .reset(reset), .manual_clk(manual_clk), .clk_select(clk_select),
    .div_value(div_value), .burst_len(burst_len[3:0]), .burst_start(burst_start),
    .halt(halt), .clk_en(clk_en_w), .cycle_count(cycle_count_w), .busy(busy_w));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic sel, input logic [7:0] d);
    reset = 1'b0; clk_select = sel; div_value = d; manual_clk = 1'b0;
    burst_start = 1'b0; halt = 1'b0; burst_len = '0;
    cyc(); cyc();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; clk_select = 1'b0; div_value = 8'd0; manual_clk = 1'b0;
    burst_start = 1'b0; halt = 1'b0; burst_len = '0;
    cyc(); cyc(); cyc();
    total++; if (clk_en !== 1'b0) begin bad++; $display("FAIL reset_clk_en got %0b want 0", clk_en); end
    total++; if (cycle_count !== 16'd0) begin bad++; $display("FAIL reset_count got %0d want 0", cycle_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    total++; if (cycle_count_w !== 4'd0) begin bad++; $display("FAIL reset_count_w got %0d want 0", cycle_count_w); end
  endtask

  // Free-run: first pulse d+2 cycles after release, then every d+1 cycles.
  task automatic test_freerun();
    for (int k = 0; k < 4; k++) begin
      int d, cnt;
      logic exp;
      d = (k == 0) ? 4 : $urandom_range(0, 6);
      do_reset(1'b0, 8'(d));
      cnt = 0;
      for (int i = 1; i <= 3 * (d + 1) + 6; i++) begin
        cyc();
        exp = (i >= 2 + d) && (((i - 2 - d) % (d + 1)) == 0);
        if (exp) cnt++;
        total++; if (clk_en !== exp) begin bad++; $display("FAIL freerun_en d=%0d i=%0d got %0b want %0b", d, i, clk_en, exp); end
        total++; if (cycle_count !== 16'(cnt)) begin bad++; $display("FAIL freerun_count d=%0d i=%0d got %0d want %0d", d, i, cycle_count, cnt); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL freerun_busy d=%0d i=%0d got %0b want 1", d, i, busy); end
      end
    end
  endtask

  // Manual: clean press gives one pulse DEB+3 cycles later; short bounces none.
  task automatic test_manual();
    do_reset(1'b1, 8'd4);
    repeat (6) cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL manual_idle_busy got %0b want 0", busy); end
    manual_clk = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      total++; if (clk_en !== (i == DEB + 3)) begin bad++; $display("FAIL manual_press i=%0d got %0b want %0b", i, clk_en, (i == DEB + 3)); end
    end
    total++; if (cycle_count !== 16'd1) begin bad++; $display("FAIL manual_count got %0d want 1", cycle_count); end
    manual_clk = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      total++; if (clk_en !== 1'b0) begin bad++; $display("FAIL manual_release i=%0d got %0b want 0", i, clk_en); end
    end
    for (int b = 0; b < 6; b++) begin
      int len, gap;
      len = $urandom_range(1, DEB - 1);
      gap = $urandom_range(1, 3);
      manual_clk = 1'b1;
      repeat (len) begin
        cyc();
        total++; if (clk_en !== 1'b0) begin bad++; $display("FAIL bounce_hi b=%0d got %0b want 0", b, clk_en); end
      end
      manual_clk = 1'b0;
      repeat (gap) begin
        cyc();
        total++; if (clk_en !== 1'b0) begin bad++; $display("FAIL bounce_lo b=%0d got %0b want 0", b, clk_en); end
      end
    end
    repeat (8) begin
      cyc();
      total++; if (clk_en !== 1'b0) begin bad++; $display("FAIL bounce_tail got %0b want 0", clk_en); end
    end
    total++; if (cycle_count !== 16'd1) begin bad++; $display("FAIL bounce_count got %0d want 1", cycle_count); end
  endtask

  // Several presses in a row, each yields exactly one pulse.
  task automatic test_back_to_back();
    int n, cnt;
    n = $urandom_range(3, 5);
    cnt = int'(cycle_count);
    for (int p = 0; p < n; p++) begin
      int h;
      h = $urandom_range(DEB, DEB + 5);
      manual_clk = 1'b1;
      for (int i = 1; i <= h + DEB + 4; i++) begin
        cyc();
        total++; if (clk_en !== (i == DEB + 3)) begin bad++; $display("FAIL b2b_en p=%0d i=%0d got %0b want %0b", p, i, clk_en, (i == DEB + 3)); end
        if (i == h) manual_clk = 1'b0;
      end
      cnt++;
      total++; if (cycle_count !== 16'(cnt)) begin bad++; $display("FAIL b2b_count p=%0d got %0d want %0d", p, cycle_count, cnt); end
    end
  endtask

  // Burst: len pulses spaced d+1 cycles, busy through the last pulse.
  task automatic test_burst();
    int cnt;
    do_reset(1'b1, 8'd4);
    repeat (6) cyc();
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      int d, len, last;
      logic exp_en, exp_busy;
      d   = (k == 0) ? 2 : $urandom_range(0, 4);
      len = (k == 0) ? 3 : $urandom_range(1, 5);
      last = 1 + len * (d + 1);
      div_value = 8'(d); burst_len = 16'(len); burst_start = 1'b1;
      for (int i = 1; i <= last + 4; i++) begin
        cyc();
        if (i == 1) burst_start = 1'b0;
        exp_en   = (i > 1) && (((i - 1) % (d + 1)) == 0) && (i <= last);
        exp_busy = (i <= last);
        if (exp_en) cnt++;
        total++; if (clk_en !== exp_en) begin bad++; $display("FAIL burst_en d=%0d n=%0d i=%0d got %0b want %0b", d, len, i, clk_en, exp_en); end
        total++; if (busy !== exp_busy) begin bad++; $display("FAIL burst_busy d=%0d n=%0d i=%0d got %0b want %0b", d, len, i, busy, exp_busy); end
      end
      total++; if (cycle_count !== 16'(cnt)) begin bad++; $display("FAIL burst_count got %0d want %0d", cycle_count, cnt); end
    end
    burst_len = '0; burst_start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      burst_start = 1'b0;
      total++; if (clk_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL burst_zero i=%0d got en=%0b busy=%0b want 0 0", i, clk_en, busy); end
    end
  endtask

  // Halt in free-run freezes pulses and count; halt in burst discards it.
  task automatic test_halt();
    int cnt, h;
    do_reset(1'b0, 8'd0);
    cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (i >= 2) cnt++;
      total++; if (clk_en !== (i >= 2)) begin bad++; $display("FAIL halt_pre i=%0d got %0b want %0b", i, clk_en, (i >= 2)); end
    end
    halt = 1'b1;
    h = $urandom_range(2, 6);
    for (int i = 1; i <= h; i++) begin
      cyc();
      total++; if (clk_en !== 1'b0) begin bad++; $display("FAIL halt_en i=%0d got %0b want 0", i, clk_en); end
      total++; if (cycle_count !== 16'(cnt)) begin bad++; $display("FAIL halt_count i=%0d got %0d want %0d", i, cycle_count, cnt); end
    end
    halt = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (i >= 2) cnt++;
      total++; if (clk_en !== (i >= 2)) begin bad++; $display("FAIL halt_post i=%0d got %0b want %0b", i, clk_en, (i >= 2)); end
      total++; if (cycle_count !== 16'(cnt)) begin bad++; $display("FAIL halt_post_count i=%0d got %0d want %0d", i, cycle_count, cnt); end
    end
    do_reset(1'b1, 8'd4);
    repeat (6) cyc();
    div_value = 8'd1; burst_len = 16'd6; burst_start = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      cyc();
      burst_start = 1'b0;
      if (i == 3) halt = 1'b1;
      if (i == 5) halt = 1'b0;
      total++; if (clk_en !== (i == 3)) begin bad++; $display("FAIL halt_burst_en i=%0d got %0b want %0b", i, clk_en, (i == 3)); end
      total++; if (busy !== (i <= 3)) begin bad++; $display("FAIL halt_burst_busy i=%0d got %0b want %0b", i, busy, (i <= 3)); end
    end
    total++; if (cycle_count !== 16'd1) begin bad++; $display("FAIL halt_burst_count got %0d want 1", cycle_count); end
  endtask

  // 4-bit counter: 17 steps read ...15, 0, 1.
  task automatic test_wrap();
    do_reset(1'b0, 8'd0);
    for (int i = 1; i <= 18; i++) begin
      int p;
      cyc();
      p = (i >= 2) ? (i - 1) : 0;
      total++; if (cycle_count_w !== 4'(p % 16)) begin bad++; $display("FAIL wrap_count i=%0d got %0d want %0d", i, cycle_count_w, p % 16); end
    end
  endtask

  // Reset in the middle of a burst clears everything asynchronously.
  task automatic test_reset_mid();
    do_reset(1'b1, 8'd4);
    repeat (6) cyc();
    div_value = 8'd2; burst_len = 16'd5; burst_start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      burst_start = 1'b0;
    end
    total++; if (clk_en !== 1'b1) begin bad++; $display("FAIL mid_pulse got %0b want 1", clk_en); end
    #2 reset = 1'b0;
    #1;
    total++; if (clk_en !== 1'b0) begin bad++; $display("FAIL mid_rst_en got %0b want 0", clk_en); end
    total++; if (cycle_count !== 16'd0) begin bad++; $display("FAIL mid_rst_count got %0d want 0", cycle_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got %0b want 0", busy); end
    cyc();
    reset = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      total++; if (clk_en !== 1'b0) begin bad++; $display("FAIL mid_after_en i=%0d got %0b want 0", i, clk_en); end
      if (i >= 4) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_after_busy i=%0d got %0b want 0", i, busy); end
      end
    end
    total++; if (cycle_count !== 16'd0) begin bad++; $display("FAIL mid_after_count got %0d want 0", cycle_count); end
  endtask

  initial begin
    test_reset();
    test_freerun();
    test_manual();
    test_back_to_back();
    test_burst();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
